// File: rtl/buzz_pkg.sv
// rtl/buzz_pkg.sv - shared level encodings and beat pattern masks for the buzzer driver
//
// Purpose: constants shared by buzz_pattern_driver and buzz_channel.
// Contents: level_e urgency codes, PHASE_W, PATTERN_MASK table, pattern_gate().

package buzz_pkg;

  // Beat phase counts 0..3; the pattern masks are 4 bits wide, one bit per phase.
  localparam int PHASE_W = 2;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_SLOW = 2'd1,
    LVL_FAST = 2'd2,
    LVL_CONT = 2'd3
  } level_e;

  // Row = level, bit = phase. Phase 0 is always the first beat of a pattern,
  // so every audible level starts with an ON beat.
  localparam logic [3:0][3:0] PATTERN_MASK = {
    4'b1111,  // LVL_CONT
    4'b0101,  // LVL_FAST
    4'b0001,  // LVL_SLOW
    4'b0000   // LVL_OFF
  };

  function automatic logic pattern_gate(input level_e lvl, input logic [PHASE_W-1:0] phase);
    return PATTERN_MASK[lvl][phase];
  endfunction

endpackage

// File: rtl/buzz_channel.sv
// rtl/buzz_channel.sv - one buzzer channel: level capture, beat sequencer and output registers
//
// Purpose: gates the shared tone with the beat pattern selected by the urgency level.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   enable_i        low = hold sequencer at phase 0 and mute outputs
//   level_i [1:0]   urgency code for this channel
//   tone_i          shared square-wave tone (registered in the top)
//   active_o        registered pattern gate
//   buzzer_o        registered gate AND tone

module buzz_channel
  import buzz_pkg::*;
#(
  parameter int BEAT_CYCLES = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [1:0] level_i,
  input  logic       tone_i,
  output logic       active_o,
  output logic       buzzer_o
);

  level_e               lvl_q;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 active_q, buzzer_q;
  logic                 level_change;
  logic                 beat_tc;
  logic                 gate;

  always_comb begin
    level_change = (level_e'(level_i) != lvl_q);
    beat_tc      = (beat_q == CNT_W'(BEAT_CYCLES - 1));
    gate         = pattern_gate(lvl_q, phase_q);

    beat_d  = beat_q;
    phase_d = phase_q;
    if (!enable_i || level_change) begin
      // A new level (or a fresh enable) restarts the pattern with a full
      // phase-0 beat; this wins over a coincident terminal count.
      beat_d  = '0;
      phase_d = '0;
    end else if (beat_tc) begin
      beat_d  = '0;
      phase_d = phase_q + PHASE_W'(1);
    end else begin
      beat_d  = beat_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q    <= LVL_OFF;
      beat_q   <= '0;
      phase_q  <= '0;
      active_q <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      // Level is tracked even while disabled so re-enable does not see a
      // spurious change.
      lvl_q    <= level_e'(level_i);
      beat_q   <= beat_d;
      phase_q  <= phase_d;
      active_q <= enable_i & gate;
      buzzer_q <= enable_i & gate & tone_i;
    end
  end

  assign active_o = active_q;
  assign buzzer_o = buzzer_q;

endmodule

// File: rtl/buzz_pattern_driver.sv
// rtl/buzz_pattern_driver.sv - left/right urgency levels to registered piezo drive signals
//
// Purpose: shared tone generator plus two buzz_channel instances.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable                      high = drive buzzers, low = mute and restart patterns
//   left_level, right_level     2-bit urgency codes (0 silent .. 3 continuous)
//   left_buzzer, right_buzzer   registered piezo drive
//   left_active, right_active   registered pattern gate

module buzz_pattern_driver
  import buzz_pkg::*;
#(
  parameter int TONE_HALF   = 12500,
  parameter int BEAT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] left_level,
  input  logic [1:0] right_level,
  output logic       left_buzzer,
  output logic       right_buzzer,
  output logic       left_active,
  output logic       right_active
);

  localparam int CNT_W = $clog2((TONE_HALF > BEAT_CYCLES) ? TONE_HALF : BEAT_CYCLES);

  logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
  logic             tone_q, tone_d;

  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (!enable) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (tone_cnt_q == CNT_W'(TONE_HALF - 1)) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end else begin
      tone_cnt_d = tone_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
    end
  end

  buzz_channel #(
    .BEAT_CYCLES(BEAT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_left (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .enable_i(enable),
    .level_i (left_level),
    .tone_i  (tone_q),
    .active_o(left_active),
    .buzzer_o(left_buzzer)
  );

  buzz_channel #(
    .BEAT_CYCLES(BEAT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_right (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .enable_i(enable),
    .level_i (right_level),
    .tone_i  (tone_q),
    .active_o(right_active),
    .buzzer_o(right_buzzer)
  );

endmodule

// File: tb/tb_buzz_pattern_driver.sv
// tb/tb_buzz_pattern_driver.sv - self-checking bench for buzz_pattern_driver

module tb_buzz_pattern_driver;

  localparam int TH = 2;
  localparam int BC = 16;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] left_level;
  logic [1:0] right_level;
  logic       left_buzzer, right_buzzer, left_active, right_active;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: edges counted since the pattern (or tone) last started.
  int m_n;
  int m_lvl [2];
  int m_t   [2];

  buzz_pattern_driver #(
    .TONE_HALF  (TH),
    .BEAT_CYCLES(BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .left_level  (left_level),
    .right_level (right_level),
    .left_buzzer (left_buzzer),
    .right_buzzer(right_buzzer),
    .left_active (left_active),
    .right_active(right_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_gate(input int lvl, input int t);
    int ph;
    ph = (t / BC) % 4;
    case (lvl)
      0:       return 1'b0;
      1:       return ph == 0;
      2:       return (ph % 2) == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s at %0t: observed %0b expected %0b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 0;
      m_t[c]   = 0;
    end
  endtask

  // One clock edge with the given inputs; model predicts, then all outputs are checked.
  task automatic step(input logic en, input logic [1:0] ll, input logic [1:0] rl);
    logic tone;
    logic ea [2];
    int   lv;
    enable      = en;
    left_level  = ll;
    right_level = rl;
    @(posedge clk);
    tone = ((m_n / TH) % 2) == 1;
    for (int c = 0; c < 2; c++) begin
      ea[c] = en && exp_gate(m_lvl[c], m_t[c]);
    end
    m_n = en ? m_n + 1 : 0;
    for (int c = 0; c < 2; c++) begin
      lv = (c == 0) ? int'(ll) : int'(rl);
      if (!en || lv != m_lvl[c]) m_t[c] = 0;
      else                       m_t[c] = m_t[c] + 1;
      m_lvl[c] = lv;
    end
    #1;
    chk("left_active",  left_active,  ea[0]);
    chk("left_buzzer",  left_buzzer,  ea[0] & tone);
    chk("right_active", right_active, ea[1]);
    chk("right_buzzer", right_buzzer, ea[1] & tone);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_left_active",  left_active,  1'b0);
    chk("rst_left_buzzer",  left_buzzer,  1'b0);
    chk("rst_right_active", right_active, 1'b0);
    chk("rst_right_buzzer", right_buzzer, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bound_fail(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: condition not reached within bound", tag);
  endtask

  logic       en_r;
  logic [1:0] ll_r, rl_r;
  int         guard;

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    left_level  = 2'd0;
    right_level = 2'd0;
    model_reset();
    @(posedge clk);
    #2;
    chk("reset_left_active",  left_active,  1'b0);
    chk("reset_left_buzzer",  left_buzzer,  1'b0);
    chk("reset_right_active", right_active, 1'b0);
    chk("reset_right_buzzer", right_buzzer, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: continuous left from reset release
    step(1'b1, 2'd3, 2'd0);
    chk("t1_edge1_inactive", left_active, 1'b0);
    step(1'b1, 2'd3, 2'd0);
    chk("t1_edge2_active", left_active, 1'b1);
    for (int i = 0; i < 70; i++) step(1'b1, 2'd3, 2'd0);

    // 2: slow right
    for (int i = 0; i < 140; i++) step(1'b1, 2'd3, 2'd1);

    // 3: fast left, switch to slow at beat cycle 10 of an OFF beat
    guard = 0;
    step(1'b1, 2'd2, 2'd1);
    while (!(((m_t[0] / BC) % 2) == 1 && (m_t[0] % BC) == 10) && guard < 200) begin
      step(1'b1, 2'd2, 2'd1);
      guard++;
    end
    if (guard >= 200) bound_fail("t3_find_off_beat");
    step(1'b1, 2'd1, 2'd1);
    step(1'b1, 2'd1, 2'd1);
    chk("t3_restart_active", left_active, 1'b1);
    for (int i = 0; i < 70; i++) step(1'b1, 2'd1, 2'd1);

    // 4: fast left, drop enable mid ON beat for 5 cycles
    guard = 0;
    step(1'b1, 2'd2, 2'd0);
    while (!(((m_t[0] / BC) % 2) == 0 && (m_t[0] % BC) == 5) && guard < 200) begin
      step(1'b1, 2'd2, 2'd0);
      guard++;
    end
    if (guard >= 200) bound_fail("t4_find_on_beat");
    step(1'b0, 2'd2, 2'd0);
    chk("t4_muted", left_active, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd2, 2'd0);
    step(1'b1, 2'd2, 2'd0);
    chk("t4_reenable_active", left_active, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 2'd2, 2'd0);

    // 5: asynchronous reset with both channels continuous
    for (int i = 0; i < 10; i++) step(1'b1, 2'd3, 2'd3);
    async_reset();
    step(1'b1, 2'd3, 2'd3);
    step(1'b1, 2'd3, 2'd3);
    chk("t5_left_back",  left_active,  1'b1);
    chk("t5_right_back", right_active, 1'b1);

    // 6: level change coincident with beat terminal count
    guard = 0;
    step(1'b1, 2'd1, 2'd2);
    while (!((m_t[0] % BC) == BC - 1 && ((m_t[0] / BC) % 4) == 0) && guard < 200) begin
      step(1'b1, 2'd1, 2'd2);
      guard++;
    end
    if (guard >= 200) bound_fail("t6_find_tc");
    step(1'b1, 2'd2, 2'd2);
    for (int i = 0; i < 40; i++) step(1'b1, 2'd2, 2'd2);

    // Randomized traffic
    en_r = 1'b1;
    ll_r = 2'd0;
    rl_r = 2'd0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) ll_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) rl_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) en_r = ~en_r;
      if ($urandom_range(0, 499) == 0) async_reset();
      step(en_r, ll_r, rl_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
